// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: bus widths, memory op codes, exception codes
// and the MEM engine state encoding.
package mem_access_unit_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    localparam logic [3:0] MEM_OP_NOP = 4'h0;
    localparam logic [3:0] MEM_OP_LB  = 4'h1;
    localparam logic [3:0] MEM_OP_LBU = 4'h2;
    localparam logic [3:0] MEM_OP_LH  = 4'h3;
    localparam logic [3:0] MEM_OP_LHU = 4'h4;
    localparam logic [3:0] MEM_OP_LW  = 4'h5;
    localparam logic [3:0] MEM_OP_SB  = 4'h6;
    localparam logic [3:0] MEM_OP_SH  = 4'h7;
    localparam logic [3:0] MEM_OP_SW  = 4'h8;

    localparam logic [1:0] MEM_EXC_NONE        = 2'd0;
    localparam logic [1:0] MEM_EXC_LOAD_ADDR   = 2'd1;
    localparam logic [1:0] MEM_EXC_STORE_ADDR  = 2'd2;
    localparam logic [1:0] MEM_EXC_BUS_TIMEOUT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } mau_state_e;

    function automatic logic mem_op_is_load(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
               (op == MEM_OP_LHU) || (op == MEM_OP_LW);
    endfunction

    function automatic logic mem_op_is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane steering for the data bus: lane selects, replicated
// store data, sign/zero-extended load extraction and alignment check.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [RegBus-1:0] sdata,
    input  logic [RegBus-1:0] rdata,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] load_data,
    output logic              misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    // Byte 0 lives in bits [31:24].
    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[31:24];
            2'd1:    byte_lane = rdata[23:16];
            2'd2:    byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
    end

    assign half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    assign byte_sel  = 4'b1000 >> addr_lo;
    assign half_sel  = addr_lo[1] ? 4'b0011 : 4'b1100;

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        sel        = 4'b0000;
        wdata      = ZeroWord;
        load_data  = ZeroWord;
        misaligned = 1'b0;
        case (op)
            MEM_OP_LB, MEM_OP_LBU: begin
                sel       = byte_sel;
                load_data = (op == MEM_OP_LB) ? {{24{byte_lane[7]}}, byte_lane}
                                              : {24'h0, byte_lane};
            end
            MEM_OP_LH, MEM_OP_LHU: begin
                sel        = half_sel;
                misaligned = addr_lo[0];
                load_data  = (op == MEM_OP_LH) ? {{16{half_lane[15]}}, half_lane}
                                               : {16'h0, half_lane};
            end
            MEM_OP_LW: begin
                sel        = 4'b1111;
                misaligned = |addr_lo;
                load_data  = rdata;
            end
            MEM_OP_SB: begin
                sel   = byte_sel;
                wdata = {4{sdata[7:0]}};
            end
            MEM_OP_SH: begin
                sel        = half_sel;
                misaligned = addr_lo[0];
                wdata      = {2{sdata[15:0]}};
            end
            MEM_OP_SW: begin
                sel        = 4'b1111;
                misaligned = |addr_lo;
                wdata      = sdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage MIPS32 pipeline: runs the req/ack data-bus
// transaction, stalls until it answers or times out, and drives MEM/WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [RegBus-1:0]     mem_wdata,
    input  logic [3:0]            mem_op,
    input  logic [RegBus-1:0]     mem_addr,
    input  logic [RegBus-1:0]     mem_sdata,
    input  logic [RegBus-1:0]     dbus_rdata,
    input  logic                  dbus_ack,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [RegBus-1:0]     dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [RegBus-1:0]     dbus_wdata,
    output logic                  stallreq,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [RegBus-1:0]     wb_wdata,
    output logic [1:0]            mem_exc
);

    mau_state_e        state;
    logic [7:0]        ack_cnt;
    logic [3:0]        lane_sel;
    logic [RegBus-1:0] lane_wdata;
    logic [RegBus-1:0] lane_load;
    logic              lane_misaligned;
    logic              op_load;
    logic              op_store;
    logic              cnt_last;

    assign op_load  = mem_op_is_load(mem_op);
    assign op_store = mem_op_is_store(mem_op);
    assign cnt_last = (ack_cnt == 8'(ACK_TIMEOUT - 1));

    mem_lane_fmt u_lane_fmt (
        .op         (mem_op),
        .addr_lo    (mem_addr[1:0]),
        .sdata      (mem_sdata),
        .rdata      (dbus_rdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_misaligned)
    );

    // The stall releases in the ack cycle and in the final timeout cycle so the
    // pipeline advances on the same edge that retires the access.
    always_comb begin
        if (state == BUS) stallreq = !dbus_ack && !cnt_last;
        else              stallreq = (op_load || op_store) && !lane_misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ack_cnt    <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= ZeroWord;
            dbus_sel   <= 4'b0000;
            dbus_wdata <= ZeroWord;
            wb_wd      <= NOPRegAddr;
            wb_wreg    <= 1'b0;
            wb_wdata   <= ZeroWord;
            mem_exc    <= MEM_EXC_NONE;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (!(op_load || op_store)) begin
                        wb_wd    <= mem_wd;
                        wb_wreg  <= mem_wreg;
                        wb_wdata <= mem_wdata;
                        mem_exc  <= MEM_EXC_NONE;
                    end else if (lane_misaligned) begin
                        wb_wd    <= NOPRegAddr;
                        wb_wreg  <= 1'b0;
                        wb_wdata <= ZeroWord;
                        mem_exc  <= op_load ? MEM_EXC_LOAD_ADDR : MEM_EXC_STORE_ADDR;
                    end else begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= op_store;
                        dbus_addr  <= {mem_addr[31:2], 2'b00};
                        dbus_sel   <= lane_sel;
                        dbus_wdata <= lane_wdata;
                        ack_cnt    <= '0;
                        wb_wd      <= NOPRegAddr;
                        wb_wreg    <= 1'b0;
                        wb_wdata   <= ZeroWord;
                        mem_exc    <= MEM_EXC_NONE;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        wb_wd    <= mem_wd;
                        wb_wreg  <= op_load && mem_wreg;
                        wb_wdata <= op_load ? lane_load : ZeroWord;
                        mem_exc  <= MEM_EXC_NONE;
                        state    <= IDLE;
                    end else if (cnt_last) begin
                        dbus_req <= 1'b0;
                        wb_wd    <= NOPRegAddr;
                        wb_wreg  <= 1'b0;
                        wb_wdata <= ZeroWord;
                        mem_exc  <= MEM_EXC_BUS_TIMEOUT;
                        state    <= IDLE;
                    end else begin
                        ack_cnt  <= ack_cnt + 8'd1;
                        wb_wd    <= NOPRegAddr;
                        wb_wreg  <= 1'b0;
                        wb_wdata <= ZeroWord;
                        mem_exc  <= MEM_EXC_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
